gate_vector_seq: RTL and testbench
==================================

# gate_vector_seq

Self-checking stimulus sequencer for two-input combinational gate labs. It drives the `a`/`b` inputs of a gate under test through all four input combinations. Each vector is held for a programmable number of cycles, and the gate's output `c` is sampled on the last cycle of each vector and compared against a parameterised truth table. Mismatches are counted and a pass/fail verdict is reported. The block sits directly upstream and downstream of the gate: it feeds its inputs and consumes its output.

## Interface
- `HOLD_CYCLES`, default 100: cycles each input vector is held; legal range ≥1.
- `TRUTH`, default 4'b1000: expected `c` per vector; bit index = {a,b}. The default is AND.
- `ERR_W`, default 3: width of the error counter.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled in IDLE and DONE only.
- `a` out 1: gate input A; registered.
- `b` out 1: gate input B; registered.
- `c` in 1: gate output under test.
- `busy` out 1: high while vectors are being applied.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when `err_count`==0.
- `err_count` out ERR_W: number of mismatches in the current or last run; saturating.
- `vec_idx` out 2: index of the vector currently applied; `a`=`vec_idx[1]`, `b`=`vec_idx[0]`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `a`=`b`=0, `busy`=`done`=`pass`=0. `start`=1 moves to RUN, clears `err_count`, `vec_idx`=0, `hold_cnt`=0.
- RUN:
  - `busy`=1.
  - `hold_cnt` increments each cycle.
  - When `hold_cnt`==HOLD_CYCLES-1 at the edge:
    - compare `c` with `TRUTH[vec_idx]`;
    - on mismatch, increment `err_count`, saturating at 2^ERR_W-1;
    - if `vec_idx`==3, go to DONE; otherwise increment `vec_idx` and clear `hold_cnt`.
  - `start` is ignored in RUN.
- DONE:
  - `busy`=0, `done`=1, `pass`=(`err_count`==0).
  - `a`, `b` and `vec_idx` hold the last vector (1,1,3).
  - `start`=1 restarts exactly as from IDLE, so `done` drops on that edge.
  - Without `start`, the block stays in DONE indefinitely.
- `hold_cnt` width is $clog2(HOLD_CYCLES), minimum 1 bit. With HOLD_CYCLES=1, every RUN cycle is a sample cycle.
- Reset value of every output is 0; the FSM resets to IDLE. Reset mid-run aborts immediately and asynchronously, with no partial verdict retained.

## Timing
- Start edge E0 (`start` sampled high): after E0, `busy`=1 and `a`=`b`=0.
- Vector k is applied on cycles E(k·H) … E((k+1)·H)−1, where H = HOLD_CYCLES.
- `c` for vector k is sampled at edge E((k+1)·H), i.e. after H full cycles of settling.
- `done`, `pass` and the final `err_count` are valid after edge E(4·H); total latency is 4·H cycles.
- Error count and state transition happen on the same edge as the last sample, so `pass` is never observed stale.
- `c` is assumed combinational from `a`/`b`; no extra pipeline allowance is made.

## Configuration
- `GATE_SEQ_FIRST_FAIL_EN` defined:
  - adds output `fail_valid` (1 bit) and output `fail_idx` (2 bits);
  - on the first mismatch of a run, set `fail_valid`=1 and latch `fail_idx`=`vec_idx`; later mismatches do not overwrite them;
  - both outputs are cleared on reset and on each run start.
- Macro undefined: those ports and registers do not exist; all other behaviour is identical.

## Test plan
1. Reset: hold `rst_n`=0 with `start`=1 → `a`=`b`=`busy`=`done`=`pass`=0, `err_count`=0, `vec_idx`=0.
2. Correct AND gate, HOLD_CYCLES=4, one-cycle `start` pulse → `{a,b}`=00,01,10,11 for 4 cycles each; `done`=1 exactly 16 cycles after the start edge; `pass`=1, `err_count`=0.
3. OR gate substituted, defaults otherwise → `err_count`=2, `pass`=0. With `GATE_SEQ_FIRST_FAIL_EN`: `fail_valid`=1, `fail_idx`=1.
4. HOLD_CYCLES=1, ERR_W=2, TRUTH=4'b0000, `c` stuck at 1 → 4 mismatches; `err_count` saturates at 3; `done` 4 cycles after start.
5. `rst_n` pulsed low while `vec_idx`=2 → all outputs 0 immediately, without waiting for a clock edge. Next `start` begins at `vec_idx`=0 with `err_count`=0.
6. `start` held high continuously → no effect during RUN. On reaching DONE, `done`=1 for exactly one cycle, then the block restarts with `err_count` cleared and `vec_idx`=0.

Source files
------------

// File: rtl/gate_vector_seq.sv
// Stimulus sequencer for two-input gate labs: walks {a,b} through 00..11, samples c per vector
// and counts mismatches against TRUTH. Optional first-failure capture under GATE_SEQ_FIRST_FAIL_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | applying vectors, sampling c on the last hold cycle of each
// DONE  | verdict valid, last vector held, start restarts
module gate_vector_seq #(
  parameter int         HOLD_CYCLES = 100,
  parameter logic [3:0] TRUTH       = 4'b1000,
  parameter int         ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
`ifdef GATE_SEQ_FIRST_FAIL_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_idx
`endif
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [1:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic             fv_q, fv_d;
  logic [1:0]       fi_q, fi_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
      fv_q    <= 1'b0;
      fi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
`ifdef GATE_SEQ_FIRST_FAIL_EN
      fv_q    <= fv_d;
      fi_q    <= fi_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    err_d   = err_q;
`ifdef GATE_SEQ_FIRST_FAIL_EN
    fv_d    = fv_q;
    fi_d    = fi_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          hold_d  = '0;
          vec_d   = '0;
          err_d   = '0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
          fv_d    = 1'b0;
          fi_d    = '0;
`endif
        end
      end
      RUN: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          if (c != TRUTH[vec_q]) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
`ifdef GATE_SEQ_FIRST_FAIL_EN
            if (!fv_q) begin
              fv_d = 1'b1;
              fi_d = vec_q;
            end
`endif
          end
          // verdict and state change share the final sample edge so pass is never stale
          if (vec_q == 2'd3) begin
            state_d = DONE;
          end else begin
            vec_d  = vec_q + 1'b1;
            hold_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign vec_idx   = vec_q;
  assign err_count = err_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && (err_q == '0);
`ifdef GATE_SEQ_FIRST_FAIL_EN
  assign fail_valid = fv_q;
  assign fail_idx   = fi_q;
`endif

endmodule

// File: tb/tb_gate_vector_seq.sv
// Directed bench for gate_vector_seq: three instances cover AND/OR gates at HOLD=4,
// default parameters, and the HOLD=1 saturating configuration.
module tb_gate_vector_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic use_or = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic a0, b0, c0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [1:0] vec0;
  logic a1, b1, c1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] vec1;
  logic a2, b2, c2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [1:0] vec2;
`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic fv0, fv1, fv2;
  logic [1:0] fi0, fi1, fi2;
`endif

  assign c0 = use_or ? (a0 | b0) : (a0 & b0);
  assign c1 = a1 | b1;
  assign c2 = 1'b1;

  gate_vector_seq #(.HOLD_CYCLES(4), .TRUTH(4'b1000), .ERR_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_idx(vec0)
`ifdef GATE_SEQ_FIRST_FAIL_EN
    , .fail_valid(fv0), .fail_idx(fi0)
`endif
  );

  gate_vector_seq dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_idx(vec1)
`ifdef GATE_SEQ_FIRST_FAIL_EN
    , .fail_valid(fv1), .fail_idx(fi1)
`endif
  );

  gate_vector_seq #(.HOLD_CYCLES(1), .TRUTH(4'b0000), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_idx(vec2)
`ifdef GATE_SEQ_FIRST_FAIL_EN
    , .fail_valid(fv2), .fail_idx(fi2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dut0(input string tag, input int av, input int bv, input int vv,
                            input int busyv, input int donev, input int passv, input int errv);
    check({tag, ".a"},    32'(a0),    32'(av));
    check({tag, ".b"},    32'(b0),    32'(bv));
    check({tag, ".vec"},  32'(vec0),  32'(vv));
    check({tag, ".busy"}, 32'(busy0), 32'(busyv));
    check({tag, ".done"}, 32'(done0), 32'(donev));
    check({tag, ".pass"}, 32'(pass0), 32'(passv));
    check({tag, ".err"},  32'(err0),  32'(errv));
  endtask

  initial begin
    // reset held with start asserted
    #2 rst_n = 1'b0;
    start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    tick(); tick();
    check_dut0("reset0", 0, 0, 0, 0, 0, 0, 0);
    check("reset1.busy", 32'(busy1), 0);
    check("reset2.done", 32'(done2), 0);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check_dut0("idle0", 0, 0, 0, 0, 0, 0, 0);

    // correct AND gate, HOLD=4
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_dut0($sformatf("and_run%0d", i), (i / 4) >> 1, (i / 4) & 1, i / 4, 1, 0, 0, 0);
      tick();
    end
    check_dut0("and_done", 1, 1, 3, 0, 1, 1, 0);
    tick(); tick(); tick();
    check_dut0("and_hold", 1, 1, 3, 0, 1, 1, 0);

    // OR gate into AND truth table on dut0
    use_or = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_dut0("or0_start", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    check("or0_pre.done", 32'(done0), 0);
    tick();
    check_dut0("or0_done", 1, 1, 3, 0, 1, 0, 2);
`ifdef GATE_SEQ_FIRST_FAIL_EN
    check("or0.fail_valid", 32'(fv0), 1);
    check("or0.fail_idx",   32'(fi0), 1);
`endif

    // default parameters with OR gate
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 399; i++) tick();
    check("dflt_pre.done", 32'(done1), 0);
    check("dflt_pre.vec",  32'(vec1),  3);
    tick();
    check("dflt.done", 32'(done1), 1);
    check("dflt.pass", 32'(pass1), 0);
    check("dflt.err",  32'(err1),  2);
`ifdef GATE_SEQ_FIRST_FAIL_EN
    check("dflt.fail_valid", 32'(fv1), 1);
    check("dflt.fail_idx",   32'(fi1), 1);
`endif

    // HOLD=1, c stuck high, saturating 2-bit counter
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("sat.e0.err", 32'(err2), 0);
    check("sat.e0.busy", 32'(busy2), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("sat.e%0d.err", k), 32'(err2), 32'(k));
      check($sformatf("sat.e%0d.vec", k), 32'(vec2), 32'(k));
      check($sformatf("sat.e%0d.done", k), 32'(done2), 0);
    end
    tick();
    check("sat.done", 32'(done2), 1);
    check("sat.err",  32'(err2),  3);
    check("sat.pass", 32'(pass2), 0);

    // asynchronous reset mid-run at vec_idx=2
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("abort_pre.vec", 32'(vec0), 2);
    check("abort_pre.err", 32'(err0), 1);
    #2 rst_n = 1'b0;
    #1;
    check_dut0("abort", 0, 0, 0, 0, 0, 0, 0);
`ifdef GATE_SEQ_FIRST_FAIL_EN
    check("abort.fail_valid", 32'(fv0), 0);
`endif
    #1 rst_n = 1'b1;
    use_or = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_dut0("restart", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick();
    check_dut0("restart_done", 1, 1, 3, 0, 1, 1, 0);

    // start held high: ignored in RUN, single-cycle DONE then restart
    use_or = 1'b1;
    start0 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("hold_start.vec", 32'(vec0), 1);
    for (int i = 0; i < 10; i++) tick();
    check("hold_start_pre.done", 32'(done0), 0);
    tick();
    check_dut0("hold_start_done", 1, 1, 3, 0, 1, 0, 2);
    tick();
    check_dut0("hold_start_again", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    check("hold_start_run.busy", 32'(busy0), 1);
    check("hold_start_run.vec",  32'(vec0),  3);
    start0 = 1'b0;
    tick();
    check_dut0("hold_start_done2", 1, 1, 3, 0, 1, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
